core_seq_ctrl: RTL and testbench
================================

Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the single-issue RV32I core.
- Owns the PC and the instruction register, and drives the fetch and data-memory handshakes.
- Takes the decoder's class signals and steps each instruction through FETCH → DECODE → EXEC → (MEM) → WB.
- Gates register-file writes and PC updates to exactly one cycle per retired instruction; stops the core on trap or bus timeout.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
TIMEOUT, 255, max cycles waiting for imem_rvalid or dmem_ack before error (1..65535)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
imem_req  out  1  fetch request, held high in FETCH
imem_rvalid  in  1  fetch data valid
imem_rdata  in  32  fetched instruction
pc  out  32  current PC, also the fetch address
inst  out  32  instruction register, feeds decoder
dec_is_load  in  1  decoded load
dec_is_store  in  1  decoded store
dec_w_en  in  1  decoded register-write enable
dec_jump_en  in  1  decoded jump/branch taken
dec_trap  in  1  decoded ebreak/trap instruction
npc_in  in  32  jump target from execute
dmem_req  out  1  data access request, held high in MEM
dmem_we  out  1  store qualifier, valid with dmem_req
dmem_ack  in  1  data access complete
rf_we  out  1  register-file write strobe
retire  out  1  one-cycle pulse per completed instruction
halt  out  1  sticky, core stopped
err  out  1  sticky, timeout or misaligned target

Behaviour:
- Reset (asynchronous, any state, mid-handshake included):
  - state ← IDLE, pc ← RESET_PC, inst ← 0, timeout counter ← 0.
  - All outputs except pc are 0 while rst is high and in IDLE.
- Outputs are decoded from registered state only: imem_req = FETCH, dmem_req = MEM.
- States and transitions:
  - IDLE: always → FETCH next cycle, giving one cycle of quiet after reset release.
  - FETCH:
    - imem_req = 1.
    - On imem_rvalid: inst ← imem_rdata, → DECODE.
    - Else the counter increments; when it reaches TIMEOUT → ERR.
  - DECODE: one cycle, decoder settles on inst.
    - dec_trap = 1 → HALT.
    - Else → EXEC.
  - EXEC: one cycle.
    - dec_is_load | dec_is_store → MEM.
    - Else → WB.
  - MEM:
    - dmem_req = 1; dmem_we = dec_is_store, held stable for the whole state.
    - On dmem_ack → WB.
    - Timeout same as FETCH → ERR.
  - WB: one cycle, then → FETCH.
    - rf_we = dec_w_en; retire = 1.
    - pc ← npc_in if dec_jump_en, else pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
    - If dec_jump_en and npc_in[1:0] ≠ 0: → ERR instead, pc unchanged, rf_we = 0, retire = 0.
  - HALT: halt = 1, no requests; stays until reset.
  - ERR: err = 1 and halt = 1, no requests; stays until reset.
- Timeout counter:
  - Cleared on every state entry.
  - Width is the minimum needed to hold TIMEOUT.
- Simultaneous events:
  - imem_rvalid/dmem_ack in the same cycle the counter hits TIMEOUT → the handshake wins; no ERR.
- Ignored inputs:
  - imem_rvalid outside FETCH and dmem_ack outside MEM.
  - Decoder inputs outside DECODE/EXEC/MEM/WB.
- Latency:
  - Non-memory instruction: 4 cycles when imem_rvalid arrives in the first FETCH cycle.
  - Load/store with 1-cycle ack: 5 cycles.
- rf_we and retire are high for exactly one cycle per instruction, never in any other state.
- pc changes only in WB or on reset.

Test Plan:
- Reset release, imem_rvalid = 1 on first FETCH cycle with addi, dec_w_en = 1 → imem_req high one cycle after reset; rf_we/retire pulse 4 cycles after FETCH entry; pc 80000000 → 80000004.
- Store, dmem_ack delayed 3 cycles → dmem_req = 1 and dmem_we = 1 for 3 cycles; rf_we = 0 in WB; retire pulse once; pc + 4.
- Jump with npc_in = 80000100 → pc = 80000100 after WB. Repeat with npc_in = 80000102 → err = halt = 1, no retire, pc unchanged.
- dec_trap = 1 (inst 00100073) → HALT after DECODE; imem_req stays 0 for 20+ cycles; only reset restarts from 80000000.
- imem_rvalid withheld with TIMEOUT = 4 → err after 4 FETCH cycles. Rerun with rvalid in the expiry cycle → DECODE, no err.
- rst asserted mid-MEM with dmem_req high → dmem_req drops immediately (asynchronously); pc = 80000000; a late dmem_ack after release is ignored.

Source files
------------

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the RV32I core: owns PC and instruction register,
// drives fetch and data-memory handshakes, and steps FETCH/DECODE/EXEC/MEM/WB.
module core_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_w_en,
  input  logic        dec_jump_en,
  input  logic        dec_trap,
  input  logic [31:0] npc_in,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        retire,
  output logic        halt,
  output logic        err,
  output logic [2:0]  dbg_state_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inst_q, inst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          jump_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign jump_bad = dec_jump_en && (npc_in[1:0] != 2'b00);

  // Handshakes: imem_req / dmem_req are held high for the whole FETCH / MEM
  // state; a transfer completes in the cycle rvalid / ack is sampled high while
  // the request is up. A handshake arriving in the timeout cycle still wins.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    cnt_d    = '0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    retire   = 1'b0;
    halt     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          state_d = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: state_d = dec_trap ? S_HALT : S_EXEC;
      S_EXEC:   state_d = (dec_is_load || dec_is_store) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_is_store;
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        // A misaligned jump target aborts the instruction without retiring it.
        if (jump_bad) begin
          state_d = S_ERR;
        end else begin
          rf_we   = dec_w_en;
          retire  = 1'b1;
          pc_d    = dec_jump_en ? npc_in : pc_q + 32'd4;
          state_d = S_FETCH;
        end
      end
      S_HALT: halt = 1'b1;
      S_ERR: begin
        halt = 1'b1;
        err  = 1'b1;
      end
      default: state_d = S_ERR;
    endcase
  end

  assign pc          = pc_q;
  assign inst        = inst_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: a driver plays memory and decoder, a per-instruction
// model queues expected outcomes, and a negedge monitor checks them.
module tb_core_seq_ctrl;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          TIMEOUT  = 4;
  localparam int          W        = 115;
  localparam logic [1:0]  K_RET = 2'd0, K_HALT = 2'd1, K_ERR = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc, inst;
  logic        dec_is_load = 1'b0, dec_is_store = 1'b0, dec_w_en = 1'b0;
  logic        dec_jump_en = 1'b0, dec_trap = 1'b0;
  logic [31:0] npc_in = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic        rf_we, retire, halt, err;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  core_seq_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .inst(inst),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_w_en(dec_w_en),
    .dec_jump_en(dec_jump_en), .dec_trap(dec_trap), .npc_in(npc_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .retire(retire), .halt(halt), .err(err),
    .dbg_state_o(dbg_state)
  );

  int n_cmp = 0, n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  m_pc, m_inst;
  logic         exp_store = 1'b0;
  bit           stopped, stop_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Event layout: kind, rf_we, pc, inst, next pc, cycles from FETCH entry.
  function automatic logic [W-1:0] pack(input logic [1:0] k, input logic rfw,
      input logic [31:0] p, input logic [31:0] i, input logic [31:0] n, input int lat);
    return {k, rfw, p, i, n, 16'(lat)};
  endfunction

  logic [W-1:0] ev;
  logic         pend, prev_req, halt_seen;
  logic [31:0]  pend_pc;
  int           fcnt;

  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0; prev_req = 1'b0; halt_seen = 1'b0; fcnt = 0;
    end else begin
      fcnt = (imem_req && !prev_req) ? 1 : fcnt + 1;
      prev_req = imem_req;
      if (pend) begin
        check("next_pc", pc, pend_pc);
        pend = 1'b0;
      end
      if (dmem_req) check("dmem_we", dmem_we, exp_store);
      if (!retire) check("rf_we_without_retire", rf_we, 1'b0);
      if (retire || (halt && !halt_seen)) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_event: retire=%0b halt=%0b pc=%h, none expected", retire, halt, pc);
        end else begin
          ev = exp_q.pop_front();
          check("event_kind", retire ? K_RET : (err ? K_ERR : K_HALT), ev[114:113]);
          check("event_pc", pc, ev[111:80]);
          check("event_inst", inst, ev[79:48]);
          if (retire) begin
            check("rf_we", rf_we, ev[112]);
            check("latency", fcnt, ev[15:0]);
            pend = 1'b1;
            pend_pc = ev[47:16];
          end
        end
        if (halt) halt_seen = 1'b1;
      end
      if (halt) check("req_while_halted", {imem_req, dmem_req}, 2'b00);
    end
  end

  task automatic do_reset(input bit late_ack);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    imem_rvalid = 1'b0; dmem_ack = 1'b0;
    {dec_is_load, dec_is_store, dec_w_en, dec_jump_en, dec_trap} = '0;
    @(posedge clk); #1;
    check("events_drained", exp_q.size(), 0);
    exp_q.delete();
    check("rst_outputs", {imem_req, dmem_req, dmem_we, rf_we, retire, halt, err}, 7'b0);
    check("rst_pc", pc, RESET_PC);
    check("rst_inst", inst, 32'h0);
    m_pc = RESET_PC; m_inst = '0;
    rst = 1'b0;
    dmem_ack = late_ack;
    check("idle_quiet", {imem_req, dmem_req}, 2'b00);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("fetch_after_idle", imem_req, 1'b1);
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 jump, 4 trap. fd/ad: cycles before rvalid/ack.
  task automatic run_insn(input int kind, input logic wen, input int fd, input int ad,
      input logic [31:0] tgt, input bit abort_mem);
    logic [31:0] word, nxt;
    logic ld, st, jmp, trp;
    int n;
    n = 0;
    while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
    if (!imem_req) begin
      n_cmp++; n_fail++;
      $display("FAIL fetch_wait: imem_req=0 after 20 cycles, want 1");
      stopped = 1'b1; stop_err = err;
      return;
    end
    ld = (kind == 1); st = (kind == 2); jmp = (kind == 3); trp = (kind == 4);
    word = trp ? 32'h0010_0073 : $urandom;
    if (fd >= TIMEOUT) begin
      exp_q.push_back(pack(K_ERR, 1'b0, m_pc, m_inst, m_pc, 0));
      stopped = 1'b1; stop_err = 1'b1;
    end else begin
      m_inst = word;
      if (trp) begin
        exp_q.push_back(pack(K_HALT, 1'b0, m_pc, word, m_pc, 0));
        stopped = 1'b1; stop_err = 1'b0;
      end else if ((ld || st) && ad >= TIMEOUT && !abort_mem) begin
        exp_q.push_back(pack(K_ERR, 1'b0, m_pc, word, m_pc, 0));
        stopped = 1'b1; stop_err = 1'b1;
      end else if (jmp && tgt[1:0] != 2'b00) begin
        exp_q.push_back(pack(K_ERR, 1'b0, m_pc, word, m_pc, 0));
        stopped = 1'b1; stop_err = 1'b1;
      end else if (!abort_mem) begin
        nxt = jmp ? tgt : m_pc + 32'd4;
        exp_q.push_back(pack(K_RET, wen, m_pc, word, nxt, fd + 4 + ((ld || st) ? ad + 1 : 0)));
        m_pc = nxt;
      end
    end
    for (int k = 0; k < TIMEOUT; k++) begin
      if (k == fd) begin
        imem_rvalid = 1'b1; imem_rdata = word;
        dec_is_load = ld; dec_is_store = st; dec_w_en = wen;
        dec_jump_en = jmp; dec_trap = trp; npc_in = tgt; exp_store = st;
        @(posedge clk); #1;
        imem_rvalid = 1'b0; imem_rdata = $urandom;
        break;
      end
      imem_rdata = $urandom;
      @(posedge clk); #1;
    end
    if (fd >= TIMEOUT || trp || !(ld || st)) return;
    n = 0;
    while (!dmem_req && n < 5) begin @(posedge clk); #1; n++; end
    if (!dmem_req) begin
      n_cmp++; n_fail++;
      $display("FAIL mem_wait: dmem_req=0 after 5 cycles, want 1");
      return;
    end
    for (int k = 0; k < TIMEOUT; k++) begin
      if (abort_mem && k == 1) begin
        #2 rst = 1'b1;
        #1;
        check("abort_dmem_req", dmem_req, 1'b0);
        check("abort_pc", pc, RESET_PC);
        check("abort_inst", inst, 32'h0);
        stopped = 1'b1; stop_err = 1'b0;
        return;
      end
      if (k == ad) begin
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic sticky_check();
    repeat (20) @(posedge clk);
    #1;
    check("halt_sticky", halt, 1'b1);
    check("err_sticky", err, stop_err);
    check("pc_frozen", pc, m_pc);
  endtask

  task automatic stop_and_reset(input bit late_ack);
    if (stopped) sticky_check();
    do_reset(late_ack);
    stopped = 1'b0;
  endtask

  initial begin
    int r, kind, fd, ad;
    logic [31:0] tgt;
    stopped = 1'b0; stop_err = 1'b0;
    m_pc = RESET_PC; m_inst = '0;
    do_reset(1'b0);
    run_insn(0, 1'b1, 0, 0, 32'h0, 1'b0);
    run_insn(2, 1'b0, 0, 2, 32'h0, 1'b0);
    run_insn(1, 1'b1, 3, 3, 32'h0, 1'b0);
    run_insn(3, 1'b0, 0, 0, 32'h8000_0100, 1'b0);
    run_insn(3, 1'b1, 1, 0, 32'hFFFF_FFFC, 1'b0);
    run_insn(0, 1'b1, 0, 0, 32'h0, 1'b0);
    run_insn(3, 1'b0, 0, 0, 32'h8000_0102, 1'b0);
    stop_and_reset(1'b0);
    run_insn(4, 1'b0, 0, 0, 32'h0, 1'b0);
    stop_and_reset(1'b0);
    run_insn(0, 1'b1, TIMEOUT, 0, 32'h0, 1'b0);
    stop_and_reset(1'b0);
    run_insn(1, 1'b1, 0, TIMEOUT + 2, 32'h0, 1'b1);
    do_reset(1'b1);
    stopped = 1'b0;
    run_insn(0, 1'b1, 0, 0, 32'h0, 1'b0);
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 40 && !stopped; i++) begin
        r = $urandom_range(0, 99);
        kind = (r < 35) ? 0 : (r < 55) ? 1 : (r < 75) ? 2 : (r < 97) ? 3 : 4;
        fd = ($urandom_range(0, 19) < 18) ? $urandom_range(0, 2) : $urandom_range(3, 5);
        ad = ($urandom_range(0, 19) < 18) ? $urandom_range(0, 2) : $urandom_range(3, 5);
        tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        if ($urandom_range(0, 24) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
        run_insn(kind, 1'($urandom_range(0, 1)), fd, ad, tgt, 1'b0);
      end
      stop_and_reset(1'($urandom_range(0, 1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_cmp++; n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
